// File: rtl/fix2float_conv.sv
`default_nettype none
// ============================================================================
//  Module   : fix2float_conv
//  Purpose  : Multi-cycle converter from signed fixed-point {int_i,frac_i}
//             to a normalised float (sign, biased exponent, hidden-bit
//             mantissa). Valid/ready handshake on both sides, selectable
//             truncate / round-to-nearest-even, inexact flag, exact zero.
//  Ports    : clk, rst (async, active-low)
//             valid_i/ready_o          - input handshake (ready_o = IDLE)
//             int_i, frac_i, rnd_mode_i - input word and rounding mode
//             valid_o/ready_i          - output handshake
//             sgn_o, exp_o, man_o, inexact_o - registered result
//  Revision : 1.0 - initial release
// ============================================================================
module fix2float_conv #(
    parameter int INT_WIDTH  = 8,
    parameter int FRAC_WIDTH = 7,
    parameter int EXP_WIDTH  = 8,
    parameter int MAN_WIDTH  = 7,
    parameter int BIAS       = 127
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [INT_WIDTH-1:0]  int_i,
    input  logic [FRAC_WIDTH-1:0] frac_i,
    input  logic                  rnd_mode_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  sgn_o,
    output logic [EXP_WIDTH-1:0]  exp_o,
    output logic [MAN_WIDTH-1:0]  man_o,
    output logic                  inexact_o
);

    localparam int c_W       = INT_WIDTH + FRAC_WIDTH;
    localparam int c_LZW     = $clog2(c_W);
    // Fraction bits below the hidden one, padded with MAN_WIDTH+2 zeros so
    // the mantissa, guard and sticky slices always exist.
    localparam int c_EXT_W   = c_W + MAN_WIDTH + 1;
    localparam int c_EXP_MAX = BIAS + c_W - 1 - FRAC_WIDTH;
    localparam int c_EXP_MIN = BIAS - FRAC_WIDTH;

    // Exponent with zero leading-zero count; lz is subtracted from it.
    localparam logic [EXP_WIDTH-1:0] c_EXP_BASE = EXP_WIDTH'(c_EXP_MAX);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_NORM  = 2'd1;
    localparam logic [1:0] c_ROUND = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    generate
        if ((c_EXP_MAX >= (2 ** EXP_WIDTH) - 1) || (c_EXP_MIN <= 0)) begin : g_param_check
            $fatal(1, "fix2float_conv: BIAS/width combination overflows the exponent range");
        end
    endgenerate

    logic [1:0]           r_state;
    logic                 r_sgn;
    logic                 r_rnd;
    logic [c_W-1:0]       r_mag;
    logic [c_LZW-1:0]     r_lz;

    logic                 r_valid;
    logic                 r_sgn_out;
    logic [EXP_WIDTH-1:0] r_exp_out;
    logic [MAN_WIDTH-1:0] r_man_out;
    logic                 r_inexact;

    logic [c_W-1:0]       w_in;
    logic [c_W-1:0]       w_mag_in;
    logic [c_EXT_W-1:0]   w_ext;
    logic [MAN_WIDTH-1:0] w_man_t;
    logic                 w_guard;
    logic                 w_sticky;
    logic                 w_inc;
    logic                 w_carry;
    logic [MAN_WIDTH-1:0] w_man_r;
    logic [EXP_WIDTH-1:0] w_exp_r;

    assign w_in     = {int_i, frac_i};
    // Negating the most-negative word gives 1000..0, which is the correct
    // unsigned magnitude, so no overflow handling is needed.
    assign w_mag_in = w_in[c_W-1] ? (~w_in + c_W'(1)) : w_in;

    // Bits below the hidden one, left aligned, zero padded on the right.
    assign w_ext    = {r_mag[c_W-2:0], {(MAN_WIDTH + 2){1'b0}}};
    assign w_man_t  = w_ext[c_EXT_W-1 -: MAN_WIDTH];
    assign w_guard  = w_ext[c_EXT_W-1-MAN_WIDTH];
    assign w_sticky = |w_ext[c_EXT_W-2-MAN_WIDTH:0];

    assign w_inc    = r_rnd & w_guard & (w_sticky | w_man_t[0]);
    // An all-ones mantissa wraps to zero; the carry bumps the exponent.
    assign {w_carry, w_man_r} = {1'b0, w_man_t} + (MAN_WIDTH + 1)'(w_inc);
    assign w_exp_r  = c_EXP_BASE - EXP_WIDTH'(r_lz) + EXP_WIDTH'(w_carry);

    // The normalisation test is applied to the value being loaded/shifted,
    // so the cycle that makes the MSB 1 also moves on to ROUND.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_IDLE;
            r_sgn     <= 1'b0;
            r_rnd     <= 1'b0;
            r_mag     <= '0;
            r_lz      <= '0;
            r_valid   <= 1'b0;
            r_sgn_out <= 1'b0;
            r_exp_out <= '0;
            r_man_out <= '0;
            r_inexact <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (valid_i) begin
                        r_sgn <= w_in[c_W-1];
                        r_rnd <= rnd_mode_i;
                        r_mag <= w_mag_in;
                        r_lz  <= '0;
                        if (w_mag_in == '0) begin
                            r_state   <= c_DONE;
                            r_valid   <= 1'b1;
                            r_sgn_out <= 1'b0;
                            r_exp_out <= '0;
                            r_man_out <= '0;
                            r_inexact <= 1'b0;
                        end else if (w_mag_in[c_W-1]) begin
                            r_state <= c_ROUND;
                        end else begin
                            r_state <= c_NORM;
                        end
                    end
                end
                c_NORM: begin
                    if (r_mag[c_W-1]) begin
                        r_state <= c_ROUND;
                    end else begin
                        r_mag <= {r_mag[c_W-2:0], 1'b0};
                        r_lz  <= r_lz + c_LZW'(1);
                        if (r_mag[c_W-2]) begin
                            r_state <= c_ROUND;
                        end
                    end
                end
                c_ROUND: begin
                    r_state   <= c_DONE;
                    r_valid   <= 1'b1;
                    r_sgn_out <= r_sgn;
                    r_exp_out <= w_exp_r;
                    r_man_out <= w_man_r;
                    r_inexact <= w_guard | w_sticky;
                end
                c_DONE: begin
                    if (ready_i) begin
                        r_valid <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign ready_o   = (r_state == c_IDLE);
    assign valid_o   = r_valid;
    assign sgn_o     = r_sgn_out;
    assign exp_o     = r_exp_out;
    assign man_o     = r_man_out;
    assign inexact_o = r_inexact;

endmodule
`default_nettype wire

// File: tb/tb_fix2float_conv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fix2float_conv
//  Purpose  : Self-checking bench for fix2float_conv (default parameters):
//             directed vector table, random vectors against an arithmetic
//             reference model, backpressure, DONE-cycle and reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fix2float_conv;

    localparam int c_IW   = 8;
    localparam int c_FW   = 7;
    localparam int c_EW   = 8;
    localparam int c_MW   = 7;
    localparam int c_BIAS = 127;
    localparam int c_W    = c_IW + c_FW;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            valid_i = 1'b0;
    logic            ready_o;
    logic [c_IW-1:0] int_i = '0;
    logic [c_FW-1:0] frac_i = '0;
    logic            rnd_mode_i = 1'b0;
    logic            valid_o;
    logic            ready_i = 1'b0;
    logic            sgn_o;
    logic [c_EW-1:0] exp_o;
    logic [c_MW-1:0] man_o;
    logic            inexact_o;

    int n_checks = 0;
    int n_errors = 0;

    fix2float_conv #(
        .INT_WIDTH (c_IW),
        .FRAC_WIDTH(c_FW),
        .EXP_WIDTH (c_EW),
        .MAN_WIDTH (c_MW),
        .BIAS      (c_BIAS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .int_i     (int_i),
        .frac_i    (frac_i),
        .rnd_mode_i(rnd_mode_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .sgn_o     (sgn_o),
        .exp_o     (exp_o),
        .man_o     (man_o),
        .inexact_o (inexact_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] iv;
        logic [6:0] fv;
        bit         rnd;
        bit         sgn;
        int         ex;
        int         mn;
        bit         inx;
        int         lat;
    } vec_t;

    task automatic check(input string name, input longint got, input longint want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    // Reference: value = signed word / 2^FRAC, normalised from its top set bit.
    task automatic model(input logic [c_W-1:0] x, input bit rnd,
                         output bit s, output int ex, output int mn,
                         output bit inx, output int lat);
        int v, m, p, e, rest, sh, rem, half;
        v = int'(x);
        if (x[c_W-1]) v = v - (1 << c_W);
        s = 0; ex = 0; mn = 0; inx = 0; lat = 1;
        if (v != 0) begin
            s = (v < 0);
            m = s ? -v : v;
            p = 0;
            while ((m >> (p + 1)) != 0) p++;
            e = p - c_FW;
            rest = m - (1 << p);
            if (p >= c_MW) begin
                sh  = p - c_MW;
                mn  = rest >> sh;
                rem = rest & ((1 << sh) - 1);
                inx = (rem != 0);
                if (rnd && sh > 0) begin
                    half = 1 << (sh - 1);
                    if (rem > half || (rem == half && (mn % 2) == 1)) mn++;
                end
            end else begin
                mn = rest << (c_MW - p);
            end
            if (mn == (1 << c_MW)) begin
                mn = 0;
                e++;
            end
            ex  = e + c_BIAS;
            lat = (c_W - 1 - p) + 2;
        end
    endtask

    // One conversion; lat counts edges with the accept edge as edge 1.
    task automatic run_one(input logic [7:0] iv, input logic [6:0] fv, input bit rnd,
                           input int hold, output bit s, output int ex, output int mn,
                           output bit inx, output int lat);
        int  wait_cnt;
        bit  stable;
        wait_cnt = 0;
        while (!ready_o && wait_cnt < 50) begin
            @(posedge clk); #1; wait_cnt++;
        end
        check("ready_idle", longint'(ready_o), 1);
        @(negedge clk);
        valid_i = 1'b1; int_i = iv; frac_i = fv; rnd_mode_i = rnd; ready_i = 1'b0;
        @(posedge clk); #1;
        valid_i = 1'b0; int_i = 8'($urandom); frac_i = 7'($urandom); rnd_mode_i = ~rnd;
        lat = 1;
        while (!valid_o && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check("valid_timeout", longint'(valid_o), 1);
        s = sgn_o; ex = int'(exp_o); mn = int'(man_o); inx = inexact_o;
        check("ready_busy", longint'(ready_o), 0);
        stable = 1;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            if (valid_o !== 1'b1 || ready_o !== 1'b0 || sgn_o !== s ||
                int'(exp_o) != ex || int'(man_o) != mn || inexact_o !== inx)
                stable = 0;
        end
        check("hold_stable", longint'(stable), 1);
        @(negedge clk); ready_i = 1'b1;
        @(posedge clk); #1;
        check("valid_drop", longint'(valid_o), 0);
        check("ready_back", longint'(ready_o), 1);
        ready_i = 1'b0;
    endtask

    task automatic cmp_result(input string tag, input bit s, input int ex, input int mn,
                              input bit inx, input int lat, input bit es, input int eex,
                              input int emn, input bit einx, input int elat);
        check({tag, "_sgn"}, longint'(s), longint'(es));
        check({tag, "_exp"}, longint'(ex), longint'(eex));
        check({tag, "_man"}, longint'(mn), longint'(emn));
        check({tag, "_inexact"}, longint'(inx), longint'(einx));
        check({tag, "_latency"}, longint'(lat), longint'(elat));
    endtask

    initial begin
        vec_t vecs[10];
        bit   s, es, inx, einx;
        int   ex, mn, lat, eex, emn, elat, cnt;
        logic [c_W-1:0] rx;
        bit   rr;

        vecs[0] = '{8'h01, 7'h00, 1'b1, 1'b0, 127, 7'h00, 1'b0, 9};
        vecs[1] = '{8'hFE, 7'h40, 1'b1, 1'b1, 127, 7'h40, 1'b0, 9};
        vecs[2] = '{8'h7F, 7'h7F, 1'b1, 1'b0, 134, 7'h00, 1'b1, 3};
        vecs[3] = '{8'h7F, 7'h7F, 1'b0, 1'b0, 133, 7'h7F, 1'b1, 3};
        vecs[4] = '{8'h40, 7'h20, 1'b1, 1'b0, 133, 7'h00, 1'b1, 3};
        vecs[5] = '{8'h40, 7'h60, 1'b1, 1'b0, 133, 7'h02, 1'b1, 3};
        vecs[6] = '{8'h80, 7'h00, 1'b1, 1'b1, 134, 7'h00, 1'b0, 2};
        vecs[7] = '{8'h00, 7'h00, 1'b1, 1'b0, 0,   7'h00, 1'b0, 1};
        vecs[8] = '{8'h00, 7'h01, 1'b0, 1'b0, 120, 7'h00, 1'b0, 16};
        vecs[9] = '{8'hFF, 7'h7F, 1'b1, 1'b1, 120, 7'h00, 1'b0, 16};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", longint'(valid_o), 0);
        check("rst_ready", longint'(ready_o), 1);
        check("rst_outs", longint'({sgn_o, exp_o, man_o, inexact_o}), 0);
        @(negedge clk); rst = 1'b1;

        // Directed table; first vector also exercises 10 cycles of backpressure
        for (int k = 0; k < 10; k++) begin
            run_one(vecs[k].iv, vecs[k].fv, vecs[k].rnd, (k == 0) ? 10 : 1,
                    s, ex, mn, inx, lat);
            cmp_result($sformatf("vec%0d", k), s, ex, mn, inx, lat,
                       vecs[k].sgn, vecs[k].ex, vecs[k].mn, vecs[k].inx, vecs[k].lat);
        end

        // Randomized against the reference model
        for (int k = 0; k < 200; k++) begin
            rx = c_W'($urandom);
            if (k % 7 == 0) rx = rx >> $urandom_range(0, c_W - 1);
            rr = 1'($urandom);
            run_one(rx[c_W-1 -: c_IW], rx[c_FW-1:0], rr, $urandom_range(0, 2),
                    s, ex, mn, inx, lat);
            model(rx, rr, es, eex, emn, einx, elat);
            cmp_result($sformatf("rnd%0d", k), s, ex, mn, inx, lat,
                       es, eex, emn, einx, elat);
        end

        // DONE cycle never accepts, even with valid_i and ready_i both high
        @(negedge clk);
        valid_i = 1'b1; int_i = 8'h80; frac_i = 7'h00; rnd_mode_i = 1'b1; ready_i = 1'b1;
        @(posedge clk); #1;   // accept
        @(posedge clk); #1;   // ROUND -> DONE
        check("done_valid", longint'(valid_o), 1);
        check("done_ready", longint'(ready_o), 0);
        @(posedge clk); #1;   // DONE -> IDLE, input not taken
        check("done_no_accept_valid", longint'(valid_o), 0);
        check("done_no_accept_ready", longint'(ready_o), 1);
        valid_i = 1'b0; ready_i = 1'b0;

        // Reset mid-NORM: leave a nonzero result on the outputs first
        run_one(8'h7F, 7'h7F, 1'b0, 0, s, ex, mn, inx, lat);
        @(negedge clk);
        valid_i = 1'b1; int_i = 8'h00; frac_i = 7'h01; rnd_mode_i = 1'b0;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #2; rst = 1'b0; #1;
        check("midrst_valid", longint'(valid_o), 0);
        check("midrst_ready", longint'(ready_o), 1);
        check("midrst_outs", longint'({sgn_o, exp_o, man_o, inexact_o}), 0);
        @(negedge clk); rst = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (valid_o) cnt++;
        end
        check("midrst_no_pulse", longint'(cnt), 0);

        // Recovery after reset
        run_one(8'h01, 7'h00, 1'b1, 0, s, ex, mn, inx, lat);
        cmp_result("after_rst", s, ex, mn, inx, lat, 1'b0, 127, 0, 1'b0, 9);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/fix2float_conv.md
Name: fix2float_conv

Overview:
- Parametrised multi-cycle converter from signed fixed-point to a normalised float of the FLOG format (sign, biased exponent, hidden-bit mantissa).
- Next generation of the team's integer-to-float stage: configurable widths and bias, valid/ready handshake on both sides, selectable rounding, an inexact flag and exact-zero handling.
- Sits between the fixed-point log datapath and the bfloat16 output packer.

Parameters:
- INT_WIDTH, 8, integer-part width; two's complement, sign in MSB.
- FRAC_WIDTH, 7, fractional-part width; unsigned.
- EXP_WIDTH, 8, output exponent width.
- MAN_WIDTH, 7, output mantissa width; hidden bit not stored.
- BIAS, 127, exponent bias.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_i  in  1  input word valid.
- ready_o  out  1  converter can accept; high only in IDLE.
- int_i  in  INT_WIDTH  signed integer part.
- frac_i  in  FRAC_WIDTH  fractional part.
- rnd_mode_i  in  1  0 = truncate, 1 = round-to-nearest-even; sampled with the input.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts result.
- sgn_o  out  1  result sign.
- exp_o  out  EXP_WIDTH  biased exponent.
- man_o  out  MAN_WIDTH  mantissa.
- inexact_o  out  1  nonzero bits were discarded.

Behaviour:
- Width and value: W = INT_WIDTH+FRAC_WIDTH. Input value = signed {int_i,frac_i} / 2^FRAC_WIDTH.
- Reset (rst low, asynchronous): state = IDLE. valid_o, sgn_o, exp_o, man_o, inexact_o and all internal registers = 0. ready_o = 1 (decoded from IDLE).
- Reset mid-conversion aborts the conversion. No result is emitted.
- Outputs are registered; they change only on the DONE entry edge.
- IDLE:
  - Accept on valid_i & ready_o.
  - Latch sgn = {int_i,frac_i}[W-1] and the rounding mode.
  - mag = W-bit magnitude (two's-complement negate when negative). The most-negative input yields mag = 1 followed by zeros; no overflow.
  - If mag == 0: go to DONE with sgn_o=0, exp_o=0, man_o=0, inexact_o=0.
  - Otherwise go to NORM with shift counter lz = 0.
- NORM, one decision per cycle:
  - If mag[W-1] = 1, go to ROUND.
  - Else mag <<= 1, lz++.
- ROUND, single cycle:
  - e = (W-1-lz) - FRAC_WIDTH; exp = e + BIAS.
  - man = mag[W-2 -: MAN_WIDTH]; zero-pad on the right when W-1 < MAN_WIDTH.
  - guard = next bit below man; sticky = OR of all lower bits; inexact = guard | sticky.
  - RNE: increment when guard & (sticky | man[0]).
  - Mantissa all-ones + increment: man = 0, exp += 1.
  - Truncate: never increments.
  - Go to DONE.
- DONE: valid_o = 1 and outputs held stable while ready_i = 0. On ready_i, valid_o drops on the next edge and the state returns to IDLE.
- No new input is accepted in the DONE cycle, even when ready_i = 1.
- Latency, in edges from the accept edge to valid_o high: lz + 2 for nonzero input; 1 for zero input.
- Throughput: one conversion per accept-to-handshake cycle, so at most one conversion in flight.
- Parameter sets must satisfy BIAS + max e < 2^EXP_WIDTH - 1 and BIAS + min e > 0. An elaboration-time assertion enforces this; no saturation logic.

Test Plan:
1. Unity, default params: int_i=8'h01, frac_i=7'h00, RNE, ready_i=1 -> valid_o 9 edges after accept; sgn_o=0, exp_o=127, man_o=7'h00, inexact_o=0.
2. Negative with fraction: int_i=8'hFE, frac_i=7'h40 (-1.5) -> sgn_o=1, exp_o=127, man_o=7'h40, inexact_o=0.
3. Rounding: int_i=8'h7F, frac_i=7'h7F.
   - RNE: exp_o=134, man_o=7'h00, inexact_o=1 (mantissa carry).
   - Truncate: exp_o=133, man_o=7'h7F, inexact_o=1.
4. Ties, RNE: int_i=8'h40.
   - frac_i=7'h20: exp_o=133, man_o=7'h00, inexact_o=1 (even, no increment).
   - frac_i=7'h60: man_o=7'h02.
5. Extremes:
   - int_i=8'h80, frac_i=0: sgn_o=1, exp_o=134, man_o=0, latency 2.
   - int_i=0, frac_i=0: all outputs 0, latency 1, ready_o high again after handshake.
6. Backpressure and reset:
   - Hold ready_i=0 for 10 cycles in DONE: outputs stable, ready_o=0.
   - Then pulse ready_i: valid_o drops next edge.
   - Separately, pull rst low mid-NORM: all outputs 0 immediately, ready_o=1, no valid_o pulse.
